// File: rtl/agu_stage.sv
// Address generation: effective address, store lane alignment, misalignment check into one output slot.
// Latency: request accepted at edge N presents cmd or exception just after edge N (one register stage).
// Backpressure: a full slot holds its outputs until fire; input ready only when empty or firing, never during flush.
module agu_stage #(
    parameter int XLEN      = 32,
    parameter int ADDR_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   agu_i_valid,
    output logic                   agu_i_ready,
    input  logic                   agu_i_load,
    input  logic                   agu_i_store,
    input  logic [1:0]             agu_i_size,
    input  logic                   agu_i_usign,
    input  logic [4:0]             agu_i_rdidx,
    input  logic [XLEN-1:0]        agu_i_rs1,
    input  logic [XLEN-1:0]        agu_i_imm,
    input  logic [XLEN-1:0]        agu_i_rs2,
    input  logic                   agu_i_flush,

    output logic                   agu_icb_cmd_valid,
    input  logic                   agu_icb_cmd_ready,
    output logic [ADDR_SIZE-1:0]   agu_icb_cmd_addr,
    output logic                   agu_icb_cmd_read,
    output logic [XLEN-1:0]        agu_icb_cmd_wdata,
    output logic [XLEN/8-1:0]      agu_icb_cmd_wmask,
    output logic [1:0]             agu_icb_cmd_size,
    output logic                   agu_icb_cmd_usign,
    output logic [4:0]             agu_icb_cmd_rdidx,

    output logic                   agu_o_excp_valid,
    input  logic                   agu_o_excp_ready,
    output logic                   agu_o_excp_ld,
    output logic                   agu_o_excp_st,
    output logic [ADDR_SIZE-1:0]   agu_o_excp_badaddr
);

    localparam int MW = XLEN / 8;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t              state;
    logic [XLEN-1:0]     sum;
    logic [ADDR_SIZE-1:0] eff_addr;
    logic                fire;
    logic                accept;
    logic                is_mem;
    logic                is_store;
    logic                misaligned;
    logic [XLEN-1:0]     st_data;
    logic [MW-1:0]       st_mask;

    // Carry-out is dropped: the address wraps modulo 2^ADDR_SIZE.
    assign sum      = agu_i_rs1 + agu_i_imm;
    assign eff_addr = sum[ADDR_SIZE-1:0];

    // Both kinds high resolves to store.
    assign is_store = agu_i_store;
    assign is_mem   = agu_i_load || agu_i_store;

    assign misaligned = (agu_i_size == 2'd3)
                     || ((agu_i_size == 2'd1) && eff_addr[0])
                     || ((agu_i_size == 2'd2) && (eff_addr[1:0] != 2'b00));

    assign fire   = (agu_icb_cmd_valid && agu_icb_cmd_ready)
                 || (agu_o_excp_valid && agu_o_excp_ready);

    // Ready is held low while reset is asserted so nothing is accepted across release.
    assign agu_i_ready = rst_n && !agu_i_flush && ((state == S_EMPTY) || fire);
    assign accept      = agu_i_valid && agu_i_ready;

    // Replicate store data across lanes and place the byte enables by size and low address bits.
    always_comb begin
        st_data = agu_i_rs2;
        st_mask = '1;
        case (agu_i_size)
            2'd0: begin
                st_data = {4{agu_i_rs2[7:0]}};
                st_mask = 4'b0001 << eff_addr[1:0];
            end
            2'd1: begin
                st_data = {2{agu_i_rs2[15:0]}};
                st_mask = 4'b0011 << {eff_addr[1], 1'b0};
            end
            default: begin
                st_data = agu_i_rs2;
                st_mask = '1;
            end
        endcase
    end

    // Slot state machine with registered command/exception outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_EMPTY;
            agu_icb_cmd_valid  <= 1'b0;
            agu_icb_cmd_addr   <= '0;
            agu_icb_cmd_read   <= 1'b0;
            agu_icb_cmd_wdata  <= '0;
            agu_icb_cmd_wmask  <= '0;
            agu_icb_cmd_size   <= 2'd0;
            agu_icb_cmd_usign  <= 1'b0;
            agu_icb_cmd_rdidx  <= 5'd0;
            agu_o_excp_valid   <= 1'b0;
            agu_o_excp_ld      <= 1'b0;
            agu_o_excp_st      <= 1'b0;
            agu_o_excp_badaddr <= '0;
        end else if (agu_i_flush) begin
            // A handshake completing this cycle has already transferred; just drain the slot.
            state             <= S_EMPTY;
            agu_icb_cmd_valid <= 1'b0;
            agu_o_excp_valid  <= 1'b0;
        end else if (accept && is_mem) begin
            state              <= S_FULL;
            agu_icb_cmd_valid  <= !misaligned;
            agu_o_excp_valid   <= misaligned;
            agu_icb_cmd_addr   <= eff_addr;
            agu_icb_cmd_read   <= !is_store;
            agu_icb_cmd_wdata  <= (is_store && !misaligned) ? st_data : '0;
            agu_icb_cmd_wmask  <= (is_store && !misaligned) ? st_mask : '0;
            agu_icb_cmd_size   <= agu_i_size;
            agu_icb_cmd_usign  <= agu_i_usign;
            agu_icb_cmd_rdidx  <= agu_i_rdidx;
            agu_o_excp_ld      <= misaligned && !is_store;
            agu_o_excp_st      <= misaligned && is_store;
            agu_o_excp_badaddr <= misaligned ? eff_addr : '0;
        end else if (fire) begin
            // Fired with no replacement (or a dropped non-memory request).
            state             <= S_EMPTY;
            agu_icb_cmd_valid <= 1'b0;
            agu_o_excp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_agu_stage.sv
module tb_agu_stage;

    logic        clk;
    logic        rst_n;
    logic        agu_i_valid;
    logic        agu_i_ready;
    logic        agu_i_load;
    logic        agu_i_store;
    logic [1:0]  agu_i_size;
    logic        agu_i_usign;
    logic [4:0]  agu_i_rdidx;
    logic [31:0] agu_i_rs1;
    logic [31:0] agu_i_imm;
    logic [31:0] agu_i_rs2;
    logic        agu_i_flush;
    logic        agu_icb_cmd_valid;
    logic        agu_icb_cmd_ready;
    logic [31:0] agu_icb_cmd_addr;
    logic        agu_icb_cmd_read;
    logic [31:0] agu_icb_cmd_wdata;
    logic [3:0]  agu_icb_cmd_wmask;
    logic [1:0]  agu_icb_cmd_size;
    logic        agu_icb_cmd_usign;
    logic [4:0]  agu_icb_cmd_rdidx;
    logic        agu_o_excp_valid;
    logic        agu_o_excp_ready;
    logic        agu_o_excp_ld;
    logic        agu_o_excp_st;
    logic [31:0] agu_o_excp_badaddr;

    int checks = 0;
    int errors = 0;

    agu_stage #(.XLEN(32), .ADDR_SIZE(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .agu_i_valid        (agu_i_valid),
        .agu_i_ready        (agu_i_ready),
        .agu_i_load         (agu_i_load),
        .agu_i_store        (agu_i_store),
        .agu_i_size         (agu_i_size),
        .agu_i_usign        (agu_i_usign),
        .agu_i_rdidx        (agu_i_rdidx),
        .agu_i_rs1          (agu_i_rs1),
        .agu_i_imm          (agu_i_imm),
        .agu_i_rs2          (agu_i_rs2),
        .agu_i_flush        (agu_i_flush),
        .agu_icb_cmd_valid  (agu_icb_cmd_valid),
        .agu_icb_cmd_ready  (agu_icb_cmd_ready),
        .agu_icb_cmd_addr   (agu_icb_cmd_addr),
        .agu_icb_cmd_read   (agu_icb_cmd_read),
        .agu_icb_cmd_wdata  (agu_icb_cmd_wdata),
        .agu_icb_cmd_wmask  (agu_icb_cmd_wmask),
        .agu_icb_cmd_size   (agu_icb_cmd_size),
        .agu_icb_cmd_usign  (agu_icb_cmd_usign),
        .agu_icb_cmd_rdidx  (agu_icb_cmd_rdidx),
        .agu_o_excp_valid   (agu_o_excp_valid),
        .agu_o_excp_ready   (agu_o_excp_ready),
        .agu_o_excp_ld      (agu_o_excp_ld),
        .agu_o_excp_st      (agu_o_excp_st),
        .agu_o_excp_badaddr (agu_o_excp_badaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic ld, input logic st, input logic [1:0] sz,
                       input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2);
        agu_i_valid = 1'b1;
        agu_i_load  = ld;
        agu_i_store = st;
        agu_i_size  = sz;
        agu_i_rs1   = rs1;
        agu_i_imm   = imm;
        agu_i_rs2   = rs2;
    endtask

    task automatic idle();
        agu_i_valid = 1'b0;
        agu_i_load  = 1'b0;
        agu_i_store = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        agu_i_valid = 1'b0; agu_i_load = 1'b0; agu_i_store = 1'b0;
        agu_i_size = 2'd0; agu_i_usign = 1'b0; agu_i_rdidx = 5'd0;
        agu_i_rs1 = '0; agu_i_imm = '0; agu_i_rs2 = '0; agu_i_flush = 1'b0;
        agu_icb_cmd_ready = 1'b1; agu_o_excp_ready = 1'b1;

        // Reset state
        step(); step();
        chk("rst_cmd_valid", {31'd0, agu_icb_cmd_valid}, 32'd0);
        chk("rst_excp_valid", {31'd0, agu_o_excp_valid}, 32'd0);
        chk("rst_i_ready", {31'd0, agu_i_ready}, 32'd0);
        chk("rst_cmd_addr", agu_icb_cmd_addr, 32'd0);
        chk("rst_wdata", agu_icb_cmd_wdata, 32'd0);
        chk("rst_badaddr", agu_o_excp_badaddr, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_i_ready", {31'd0, agu_i_ready}, 32'd1);

        // sw aligned word
        req(1'b0, 1'b1, 2'd2, 32'h8000_0000, 32'h10, 32'hDEAD_BEEF);
        step();
        chk("sw_cmd_valid", {31'd0, agu_icb_cmd_valid}, 32'd1);
        chk("sw_addr", agu_icb_cmd_addr, 32'h8000_0010);
        chk("sw_read", {31'd0, agu_icb_cmd_read}, 32'd0);
        chk("sw_wdata", agu_icb_cmd_wdata, 32'hDEAD_BEEF);
        chk("sw_wmask", {28'd0, agu_icb_cmd_wmask}, 32'hF);
        chk("sw_excp_valid", {31'd0, agu_o_excp_valid}, 32'd0);
        chk("sw_b2b_ready", {31'd0, agu_i_ready}, 32'd1);

        // sb at lane 3, issued back-to-back
        req(1'b0, 1'b1, 2'd0, 32'h8000_0003, 32'h0, 32'h1234_5678);
        step();
        chk("sb_addr", agu_icb_cmd_addr, 32'h8000_0003);
        chk("sb_wdata", agu_icb_cmd_wdata, 32'h7878_7878);
        chk("sb_wmask", {28'd0, agu_icb_cmd_wmask}, 32'h8);

        // sh to upper half
        req(1'b0, 1'b1, 2'd1, 32'h8000_0002, 32'h0, 32'h1234_5678);
        step();
        chk("sh_wdata", agu_icb_cmd_wdata, 32'h5678_5678);
        chk("sh_wmask", {28'd0, agu_icb_cmd_wmask}, 32'hC);

        // lh misaligned -> exception
        req(1'b1, 1'b0, 2'd1, 32'h8000_0001, 32'h0, 32'h0);
        step();
        chk("lh_excp_valid", {31'd0, agu_o_excp_valid}, 32'd1);
        chk("lh_excp_ld", {31'd0, agu_o_excp_ld}, 32'd1);
        chk("lh_excp_st", {31'd0, agu_o_excp_st}, 32'd0);
        chk("lh_badaddr", agu_o_excp_badaddr, 32'h8000_0001);
        chk("lh_cmd_valid", {31'd0, agu_icb_cmd_valid}, 32'd0);

        // lw with address wrap
        req(1'b1, 1'b0, 2'd2, 32'hFFFF_FFFC, 32'h8, 32'h0);
        agu_i_usign = 1'b1;
        agu_i_rdidx = 5'd17;
        step();
        chk("lw_cmd_valid", {31'd0, agu_icb_cmd_valid}, 32'd1);
        chk("lw_addr", agu_icb_cmd_addr, 32'h0000_0004);
        chk("lw_read", {31'd0, agu_icb_cmd_read}, 32'd1);
        chk("lw_wmask", {28'd0, agu_icb_cmd_wmask}, 32'h0);
        chk("lw_rdidx", {27'd0, agu_icb_cmd_rdidx}, 32'd17);
        chk("lw_usign", {31'd0, agu_icb_cmd_usign}, 32'd1);
        chk("lw_excp_valid", {31'd0, agu_o_excp_valid}, 32'd0);
        idle();
        agu_i_usign = 1'b0;
        step();
        chk("drain_cmd_valid", {31'd0, agu_icb_cmd_valid}, 32'd0);

        // Stall: A held 3 cycles with B waiting, then both transfer back-to-back
        agu_icb_cmd_ready = 1'b0;
        req(1'b0, 1'b1, 2'd2, 32'h100, 32'h4, 32'hA5A5_A5A5);
        step();
        req(1'b0, 1'b1, 2'd0, 32'h200, 32'h0, 32'h1122_3344);
        for (int i = 0; i < 3; i++) begin
            chk("stall_i_ready", {31'd0, agu_i_ready}, 32'd0);
            chk("stall_cmd_valid", {31'd0, agu_icb_cmd_valid}, 32'd1);
            chk("stall_addr", agu_icb_cmd_addr, 32'h104);
            chk("stall_wdata", agu_icb_cmd_wdata, 32'hA5A5_A5A5);
            step();
        end
        agu_icb_cmd_ready = 1'b1;
        #1;
        chk("unstall_i_ready", {31'd0, agu_i_ready}, 32'd1);
        step();
        idle();
        chk("b_cmd_valid", {31'd0, agu_icb_cmd_valid}, 32'd1);
        chk("b_addr", agu_icb_cmd_addr, 32'h200);
        chk("b_wdata", agu_icb_cmd_wdata, 32'h4444_4444);
        chk("b_wmask", {28'd0, agu_icb_cmd_wmask}, 32'h1);
        step();
        chk("b_drained", {31'd0, agu_icb_cmd_valid}, 32'd0);

        // Flush with slot full and a new request pending
        agu_icb_cmd_ready = 1'b0;
        req(1'b0, 1'b1, 2'd2, 32'h300, 32'h0, 32'hCAFE_F00D);
        step();
        req(1'b1, 1'b0, 2'd2, 32'h400, 32'h0, 32'h0);
        agu_i_flush = 1'b1;
        #1;
        chk("flush_i_ready", {31'd0, agu_i_ready}, 32'd0);
        step();
        agu_i_flush = 1'b0;
        idle();
        chk("flush_cmd_valid", {31'd0, agu_icb_cmd_valid}, 32'd0);
        chk("flush_excp_valid", {31'd0, agu_o_excp_valid}, 32'd0);
        step();
        chk("flush_no_late_cmd", {31'd0, agu_icb_cmd_valid}, 32'd0);
        agu_icb_cmd_ready = 1'b1;

        // Neither load nor store: accepted and dropped
        req(1'b0, 1'b0, 2'd2, 32'h500, 32'h0, 32'h0);
        #1;
        chk("nop_i_ready", {31'd0, agu_i_ready}, 32'd1);
        step();
        idle();
        chk("nop_cmd_valid", {31'd0, agu_icb_cmd_valid}, 32'd0);
        chk("nop_excp_valid", {31'd0, agu_o_excp_valid}, 32'd0);

        // Misaligned store word, exception stalled then consumed
        agu_o_excp_ready = 1'b0;
        req(1'b0, 1'b1, 2'd2, 32'h300, 32'h2, 32'h0);
        step();
        idle();
        step();
        chk("swx_excp_valid", {31'd0, agu_o_excp_valid}, 32'd1);
        chk("swx_excp_st", {31'd0, agu_o_excp_st}, 32'd1);
        chk("swx_excp_ld", {31'd0, agu_o_excp_ld}, 32'd0);
        chk("swx_badaddr", agu_o_excp_badaddr, 32'h302);
        chk("swx_cmd_valid", {31'd0, agu_icb_cmd_valid}, 32'd0);
        agu_o_excp_ready = 1'b1;
        step();
        chk("swx_drained", {31'd0, agu_o_excp_valid}, 32'd0);

        // Load and store both high -> store byte
        req(1'b1, 1'b1, 2'd0, 32'h400, 32'h1, 32'h0000_00AB);
        step();
        chk("ldst_read", {31'd0, agu_icb_cmd_read}, 32'd0);
        chk("ldst_wmask", {28'd0, agu_icb_cmd_wmask}, 32'h2);
        chk("ldst_wdata", agu_icb_cmd_wdata, 32'hABAB_ABAB);

        // Reserved size on aligned address -> exception
        req(1'b1, 1'b0, 2'd3, 32'h500, 32'h0, 32'h0);
        step();
        idle();
        chk("sz3_excp_valid", {31'd0, agu_o_excp_valid}, 32'd1);
        chk("sz3_cmd_valid", {31'd0, agu_icb_cmd_valid}, 32'd0);
        chk("sz3_badaddr", agu_o_excp_badaddr, 32'h500);
        step();

        // Reset mid-stall drops the slot asynchronously
        agu_icb_cmd_ready = 1'b0;
        req(1'b0, 1'b1, 2'd2, 32'h600, 32'h0, 32'h1);
        step();
        idle();
        chk("pre_rst_cmd_valid", {31'd0, agu_icb_cmd_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cmd_valid", {31'd0, agu_icb_cmd_valid}, 32'd0);
        chk("async_rst_i_ready", {31'd0, agu_i_ready}, 32'd0);
        chk("async_rst_addr", agu_icb_cmd_addr, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        agu_icb_cmd_ready = 1'b1;
        step();
        chk("post_rst_no_cmd0", {31'd0, agu_icb_cmd_valid}, 32'd0);
        step();
        chk("post_rst_no_cmd1", {31'd0, agu_icb_cmd_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/agu_stage.md
# agu_stage

Address-generation stage that sits directly upstream of the LSU in the npc core. It accepts decoded load/store operations from the execute stage, computes the effective address, and aligns store data and byte masks. It either issues one ICB command to the LSU or raises a misalignment exception, through a single registered output slot with valid/ready handshakes on both sides.

## Interface
- XLEN, 32: data width; only 32 supported (4-byte lanes).
- ADDR_SIZE, 32: address width, ≤ XLEN.
- clk  input  1  clock, all state rising-edge.
- rst_n  input  1  reset; asynchronous and active-low.
- agu_i_valid  input  1  request valid.
- agu_i_ready  output  1  request accepted when valid&&ready.
- agu_i_load / agu_i_store  input  1 each  operation kind; both high is treated as store.
- agu_i_size  input  2  0 byte, 1 half, 2 word, 3 reserved.
- agu_i_usign  input  1  unsigned load flag, passed through.
- agu_i_rdidx  input  5  load destination register, passed through.
- agu_i_rs1, agu_i_imm, agu_i_rs2  input  XLEN each  base, offset, store data.
- agu_i_flush  input  1  pipeline flush.
- agu_icb_cmd_valid  output  1  command valid.
- agu_icb_cmd_ready  input  1  LSU accepts command.
- agu_icb_cmd_addr  output  ADDR_SIZE  effective address.
- agu_icb_cmd_read  output  1  1 = load, 0 = store.
- agu_icb_cmd_wdata  output  XLEN  lane-replicated store data.
- agu_icb_cmd_wmask  output  XLEN/8  byte enables.
- agu_icb_cmd_size / agu_icb_cmd_usign / agu_icb_cmd_rdidx  output  2/1/5  passed through.
- agu_o_excp_valid  output  1  misaligned-access exception valid.
- agu_o_excp_ready  input  1  exception consumed.
- agu_o_excp_ld / agu_o_excp_st  output  1 each  faulting kind.
- agu_o_excp_badaddr  output  ADDR_SIZE  faulting address.

## Operation
- Address: addr = (rs1 + imm) truncated to ADDR_SIZE bits. Carry-out is discarded, so the address wraps modulo 2^ADDR_SIZE.
- Misaligned: (size==1 && addr[0]) || (size==2 && addr[1:0]!=0) || size==3.
- Requests with neither load nor store are accepted and dropped; no output is produced.
- Load, aligned: cmd with read=1, wdata=0, wmask=0.
- Store, aligned: read=0, with wdata and wmask by size:
  - Byte: wdata={4{rs2[7:0]}}, wmask=4'b0001<<addr[1:0].
  - Half: wdata={2{rs2[15:0]}}, wmask=4'b0011<<(2*addr[1]).
  - Word: wdata=rs2, wmask=4'b1111.
- Misaligned: no cmd is issued. The slot holds an exception with excp_ld/excp_st set from the operation kind and badaddr=addr.
- Slot state machine, two states:
  - EMPTY → FULL on accept of a load/store.
  - FULL → EMPTY on fire without a new accept.
  - FULL → FULL on fire with a simultaneous accept.
- FULL drives exactly one of cmd_valid / excp_valid; never both.
- Fire: cmd_valid&&cmd_ready, or excp_valid&&excp_ready.
- agu_i_ready = !flush && (EMPTY || fire). This is combinational from the output-side ready; a full slot that fires accepts back-to-back.
- Flush:
  - Slot goes to EMPTY at the next edge.
  - No request is accepted in the flush cycle.
  - A handshake completing in the flush cycle counts as transferred.

## Timing
- Latency: a request accepted at edge N drives outputs from just after edge N; the first possible fire is in cycle N+1.
- Throughput: 1 op/cycle with the output ready held high.
- While a valid output is stalled (ready low), all output fields stay stable until fire.
- Reset (asynchronous, rst_n low): state EMPTY; cmd_valid=0, excp_valid=0; all data outputs 0; agu_i_ready=0 while reset is held. Operation resumes on the first edge after release.
- Reset mid-stall discards the slot content; no output is produced for it.

## Test plan
- sw rs1=0x8000_0000, imm=0x10, rs2=0xDEADBEEF → next cycle: cmd_valid=1, addr=0x8000_0010, read=0, wdata=0xDEADBEEF, wmask=0xF.
- sb rs1=0x8000_0003, imm=0, rs2=0x12345678 → wdata=0x78787878, wmask=0x8; sh to 0x8000_0002 → wdata=0x56785678, wmask=0xC.
- lh at addr 0x8000_0001 → excp_valid=1, excp_ld=1, badaddr=0x8000_0001, cmd_valid stays 0. lw rs1=0xFFFF_FFFC, imm=8 → cmd addr=0x0000_0004, read=1.
- cmd_ready low for 3 cycles with a second request waiting → agu_i_ready=0 and outputs stable; cmd_ready high → both commands transfer on consecutive cycles.
- Slot full plus flush with a new valid request → request not accepted; cmd_valid=0 next cycle.
- rst_n pulsed low while cmd_valid=1 is stalled → cmd_valid drops immediately without waiting for an edge; no stale command appears after reset release.
